// File: rtl/sddt_pkg.sv
// Shared types and helpers for the DDR4 read-data merge path.
package sddt_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } sddt_state_e;

  // Channel tag width; a single channel still carries a 1-bit tag.
  function automatic int ch_id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sddt_axis_skid.sv
// Two-entry registered skid buffer: output register plus one overflow slot,
// so in_ready is a flop and never sees out_ready combinationally.
module sddt_axis_skid #(
  parameter int W = 8
) (
  input  logic         axi_aclk,
  input  logic         axi_aresetn,
  input  logic [W-1:0] in_pl,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_pl,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [W-1:0] skid_pl_q;
  logic         skid_vld_q;
  logic         load_main;

  assign in_ready  = ~skid_vld_q;
  assign load_main = out_ready | ~out_valid;

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      out_pl     <= '0;
      out_valid  <= 1'b0;
      skid_pl_q  <= '0;
      skid_vld_q <= 1'b0;
    end else if (load_main) begin
      if (skid_vld_q) begin
        out_pl     <= skid_pl_q;
        out_valid  <= 1'b1;
        skid_vld_q <= 1'b0;
      end else begin
        out_valid <= in_valid;
        if (in_valid) out_pl <= in_pl;
      end
    end else if (in_valid && in_ready) begin
      // output stalled: park the beat in the overflow slot
      skid_pl_q  <= in_pl;
      skid_vld_q <= 1'b1;
    end
  end

endmodule

// File: rtl/sddt_rdata_merger.sv
// Packet-granular round-robin merge of per-channel read-data streams onto one
// host-bound AXI-Stream, tagging each beat with its source channel.
module sddt_rdata_merger
  import sddt_pkg::*;
#(
  parameter  int NUM_CH      = 2,
  parameter  int DATA_WIDTH  = 512,
  parameter  int LEN_WIDTH   = 16,
  localparam int CH_ID_WIDTH = ch_id_width(NUM_CH)
) (
  input  logic                         axi_aclk,
  input  logic                         axi_aresetn,
  input  logic [NUM_CH*DATA_WIDTH-1:0] S_AXIS_RDATA_tdata,
  input  logic [NUM_CH-1:0]            S_AXIS_RDATA_tvalid,
  output logic [NUM_CH-1:0]            S_AXIS_RDATA_tready,
  output logic [DATA_WIDTH-1:0]        M_AXIS_RDATA_tdata,
  output logic                         M_AXIS_RDATA_tvalid,
  input  logic                         M_AXIS_RDATA_tready,
  output logic                         M_AXIS_RDATA_tlast,
  output logic [DATA_WIDTH/8-1:0]      M_AXIS_RDATA_tkeep,
  output logic [CH_ID_WIDTH-1:0]       M_AXIS_RDATA_tuser,
  input  logic [LEN_WIDTH-1:0]         pkt_len,
  output logic                         busy,
  output logic [CH_ID_WIDTH-1:0]       cur_ch,
  output logic [31:0]                  pkt_count
);

  localparam int PL_W = DATA_WIDTH + 1 + CH_ID_WIDTH;
  localparam logic [CH_ID_WIDTH-1:0] LAST_CH = CH_ID_WIDTH'(NUM_CH - 1);

  sddt_state_e                       state_q, state_d;
  logic [CH_ID_WIDTH-1:0]            rr_ptr_q, gnt_q, gnt_d;
  logic                              gnt_vld, grant;
  logic [LEN_WIDTH-1:0]              len_q, beat_q;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0] ch_data;
  logic [DATA_WIDTH-1:0]             sel_data;
  logic                              sk_in_valid, sk_in_ready, in_fire, beat_last;
  logic [PL_W-1:0]                   sk_in_pl, sk_out_pl;
  logic                              out_last_fire;
  logic [2:0]                        open_q;
  int                                best_d, cand_d;

  assign ch_data = S_AXIS_RDATA_tdata;

  // Rotating priority: the valid channel closest above the pointer wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_d   = rr_ptr_q;
    best_d  = NUM_CH;
    cand_d  = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      cand_d = (c > int'(rr_ptr_q)) ? c - int'(rr_ptr_q) - 1
                                    : c + NUM_CH - int'(rr_ptr_q) - 1;
      if (S_AXIS_RDATA_tvalid[c] && cand_d < best_d) begin
        best_d  = cand_d;
        gnt_vld = 1'b1;
        gnt_d   = CH_ID_WIDTH'(c);
      end
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) state_q <= IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d             = state_q;
    S_AXIS_RDATA_tready = '0;
    sk_in_valid         = 1'b0;
    sel_data            = '0;
    unique case (state_q)
      IDLE: if (gnt_vld) state_d = XFER;
      XFER: begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (gnt_q == CH_ID_WIDTH'(c)) begin
            S_AXIS_RDATA_tready[c] = sk_in_ready;
            sk_in_valid            = S_AXIS_RDATA_tvalid[c];
            sel_data               = ch_data[c];
          end
        end
        if (sk_in_valid && sk_in_ready && beat_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant     = (state_q == IDLE) && gnt_vld;
  assign in_fire   = sk_in_valid & sk_in_ready;
  assign beat_last = (beat_q == len_q - LEN_WIDTH'(1));

  // Length is sampled only at grant so mid-packet pkt_len edits wait a packet.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      rr_ptr_q <= LAST_CH;
      gnt_q    <= '0;
      len_q    <= LEN_WIDTH'(1);
      beat_q   <= '0;
    end else if (grant) begin
      rr_ptr_q <= gnt_d;
      gnt_q    <= gnt_d;
      len_q    <= (pkt_len == '0) ? LEN_WIDTH'(1) : pkt_len;
      beat_q   <= '0;
    end else if (in_fire) begin
      beat_q <= beat_q + LEN_WIDTH'(1);
    end
  end

  assign sk_in_pl = {sel_data, beat_last, gnt_q};

  sddt_axis_skid #(
    .W (PL_W)
  ) u_skid (
    .axi_aclk    (axi_aclk),
    .axi_aresetn (axi_aresetn),
    .in_pl       (sk_in_pl),
    .in_valid    (sk_in_valid),
    .in_ready    (sk_in_ready),
    .out_pl      (sk_out_pl),
    .out_valid   (M_AXIS_RDATA_tvalid),
    .out_ready   (M_AXIS_RDATA_tready)
  );

  assign {M_AXIS_RDATA_tdata, M_AXIS_RDATA_tlast, M_AXIS_RDATA_tuser} = sk_out_pl;
  assign M_AXIS_RDATA_tkeep = '1;

  assign out_last_fire = M_AXIS_RDATA_tvalid & M_AXIS_RDATA_tready & M_AXIS_RDATA_tlast;

  // Packets granted but whose tlast has not yet left; the skid can hold the
  // tail of one packet while the next is already being granted.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      open_q    <= '0;
      pkt_count <= '0;
    end else begin
      open_q <= open_q + 3'(grant) - 3'(out_last_fire);
      if (out_last_fire) pkt_count <= pkt_count + 32'd1;
    end
  end

  assign busy   = (open_q != '0);
  assign cur_ch = gnt_q;

endmodule

// File: tb/tb_sddt_rdata_merger.sv
// Randomized bench for sddt_rdata_merger: per-channel source queues feed the
// DUT, a packet-level model predicts grant order and output framing.
module tb_sddt_rdata_merger;

  localparam int NUM_CH = 2;
  localparam int DW     = 32;
  localparam int LW     = 16;
  localparam int CW     = 1;

  logic                 axi_aclk = 1'b0;
  logic                 axi_aresetn = 1'b0;
  logic [NUM_CH*DW-1:0] s_tdata = '0;
  logic [NUM_CH-1:0]    s_tvalid = '0;
  logic [NUM_CH-1:0]    s_tready;
  logic [DW-1:0]        m_tdata;
  logic                 m_tvalid, m_tlast;
  logic                 m_tready = 1'b1;
  logic [DW/8-1:0]      m_tkeep;
  logic [CW-1:0]        m_tuser;
  logic [LW-1:0]        pkt_len = LW'(4);
  logic                 busy;
  logic [CW-1:0]        cur_ch;
  logic [31:0]          pkt_count;

  always #5 axi_aclk = ~axi_aclk;

  sddt_rdata_merger #(
    .NUM_CH     (NUM_CH),
    .DATA_WIDTH (DW),
    .LEN_WIDTH  (LW)
  ) dut (
    .axi_aclk            (axi_aclk),
    .axi_aresetn         (axi_aresetn),
    .S_AXIS_RDATA_tdata  (s_tdata),
    .S_AXIS_RDATA_tvalid (s_tvalid),
    .S_AXIS_RDATA_tready (s_tready),
    .M_AXIS_RDATA_tdata  (m_tdata),
    .M_AXIS_RDATA_tvalid (m_tvalid),
    .M_AXIS_RDATA_tready (m_tready),
    .M_AXIS_RDATA_tlast  (m_tlast),
    .M_AXIS_RDATA_tkeep  (m_tkeep),
    .M_AXIS_RDATA_tuser  (m_tuser),
    .pkt_len             (pkt_len),
    .busy                (busy),
    .cur_ch              (cur_ch),
    .pkt_count           (pkt_count)
  );

  typedef struct {
    logic [DW-1:0] data;
    int            ch;
    bit            last;
  } beat_t;

  logic [DW-1:0] src_q [NUM_CH][$];
  beat_t         exp_q[$];
  int            ulog[$];
  int  n_chk = 0, n_err = 0, cyc = 0, seq = 0;
  bit  in_pkt = 0;
  int  own = 0, prev_g = NUM_CH - 1, pkt_beats = 0, len_m = 1, exp_pkts = 0;
  bit  bubble[NUM_CH], acc_last[NUM_CH];
  bit  bp_mode = 0, gap_chk = 0, comb_chk = 0;
  int  t_last_acc = -1, t_first_acc = -1, t_first_out = -1;
  int  len_switch_to = -1, base;
  bit  stall_prev = 0;
  logic [DW-1:0]   st_data;
  logic            st_last;
  logic [CW-1:0]   st_user;
  logic [DW/8-1:0] keep_ones = '1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_grant();
    for (int k = 1; k <= NUM_CH; k++)
      if (src_q[(prev_g + k) % NUM_CH].size() > 0) return (prev_g + k) % NUM_CH;
    return -1;
  endfunction

  function automatic bit all_empty();
    for (int c = 0; c < NUM_CH; c++) if (src_q[c].size() > 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic load(input int c, input int npk, input int len);
    for (int i = 0; i < npk * len; i++) begin
      src_q[c].push_back({8'(c), 24'(seq)});
      seq++;
    end
  endtask

  // Sources hold valid until accepted; mid-packet bubbles only follow an accept.
  task automatic drive();
    for (int c = 0; c < NUM_CH; c++) begin
      if (bubble[c]) bubble[c] = ($urandom % 2) == 0;
      else if (bp_mode && acc_last[c] && in_pkt && own == c) bubble[c] = ($urandom % 4) == 0;
      acc_last[c] = 1'b0;
      s_tvalid[c] = (src_q[c].size() > 0) && !bubble[c];
      s_tdata[c*DW +: DW] = (src_q[c].size() > 0) ? src_q[c][0] : '0;
    end
    m_tready = bp_mode ? (($urandom % 2) == 1) : 1'b1;
  endtask

  task automatic monitor();
    logic [NUM_CH-1:0] rdy0;
    beat_t b;
    if (comb_chk && in_pkt) begin
      rdy0 = s_tready;
      m_tready = ~m_tready; #1;
      chk("rdy_no_comb", s_tready, rdy0);
      m_tready = ~m_tready; #1;
    end
    chk("pkt_count", pkt_count, exp_pkts);
    if (stall_prev) begin
      chk("stall_vld", m_tvalid, 1);
      chk("stall_data", m_tdata, st_data);
      chk("stall_last", m_tlast, st_last);
      chk("stall_user", m_tuser, st_user);
    end
    if (in_pkt || exp_q.size() > 0) chk("busy_hi", busy, 1);
    else if (s_tvalid == '0)        chk("busy_lo", busy, 0);
    if (in_pkt) chk("cur_ch", cur_ch, own);
    for (int c = 0; c < NUM_CH; c++) begin
      if (s_tready[c] && in_pkt && own != c) chk("rdy_owner", c, own);
      if (s_tvalid[c] && s_tready[c]) begin
        if (!in_pkt) begin
          chk("grant", c, exp_grant());
          if (gap_chk && t_last_acc >= 0) chk("in_gap", cyc - t_last_acc, 2);
          if (t_first_acc < 0) t_first_acc = cyc;
          in_pkt = 1; own = c; prev_g = c; pkt_beats = 0;
          len_m = (pkt_len == '0) ? 1 : int'(pkt_len);
        end
        b.data = src_q[c].pop_front();
        b.ch   = c;
        b.last = (pkt_beats == len_m - 1);
        exp_q.push_back(b);
        pkt_beats++;
        acc_last[c] = 1'b1;
        if (b.last) begin in_pkt = 0; t_last_acc = cyc; end
      end
    end
    if (m_tvalid && t_first_out < 0) t_first_out = cyc;
    if (m_tvalid && m_tready) begin
      if (exp_q.size() == 0) chk("out_extra", m_tvalid, 0);
      else begin
        b = exp_q.pop_front();
        chk("out_data", m_tdata, b.data);
        chk("out_user", m_tuser, b.ch);
        chk("out_last", m_tlast, b.last);
        chk("out_keep", m_tkeep, keep_ones);
        ulog.push_back(int'(m_tuser));
        if (b.last) exp_pkts++;
      end
    end
    stall_prev = m_tvalid && !m_tready;
    st_data = m_tdata; st_last = m_tlast; st_user = m_tuser;
  endtask

  task automatic cycle();
    @(negedge axi_aclk);
    monitor();
    @(posedge axi_aclk); #1;
    cyc++;
    drive();
  endtask

  task automatic run_phase(input int max_cyc, input int stop_beats);
    int n;
    bit done;
    n = 0; done = 0;
    t_first_acc = -1; t_first_out = -1; t_last_acc = -1;
    while (!done && n < max_cyc) begin
      cycle();
      n++;
      if (stop_beats > 0) done = in_pkt && pkt_beats == stop_beats;
      else done = all_empty() && !in_pkt && exp_q.size() == 0;
      if (len_switch_to >= 0 && in_pkt && pkt_beats == 2) begin
        pkt_len = LW'(len_switch_to);
        len_switch_to = -1;
      end
    end
    chk("phase_done", done, 1);
  endtask

  task automatic chk_rst_outputs(input string tag);
    chk({tag, "_s_tready"}, s_tready, 0);
    chk({tag, "_tvalid"}, m_tvalid, 0);
    chk({tag, "_tlast"}, m_tlast, 0);
    chk({tag, "_tdata"}, m_tdata, 0);
    chk({tag, "_tuser"}, m_tuser, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_cur_ch"}, cur_ch, 0);
    chk({tag, "_pkt_count"}, pkt_count, 0);
  endtask

  initial begin
    // reset held with every channel valid
    load(0, 1, 4); load(1, 1, 4);
    drive();
    repeat (3) @(negedge axi_aclk);
    chk_rst_outputs("rst");
    @(posedge axi_aclk); #1;
    axi_aresetn = 1'b1;
    run_phase(200, 0);

    // single packet from ch1
    base = exp_pkts;
    for (int i = 0; i < 4; i++) src_q[1].push_back(DW'(32'hA0 + i));
    drive();
    run_phase(200, 0);
    chk("latency", t_first_out - t_first_acc, 1);
    chk("pkt_cnt_single", pkt_count, base + 1);

    // round robin with both channels continuously valid
    pkt_len = LW'(2);
    load(0, 4, 2); load(1, 4, 2);
    ulog.delete();
    gap_chk = 1;
    drive();
    run_phase(200, 0);
    gap_chk = 0;
    chk("rr_len", ulog.size(), 16);
    for (int i = 0; i < ulog.size(); i++) chk("rr_user", ulog[i], (i / 2) % 2);

    // backpressure: 64 beats with random tready and source bubbles
    bp_mode = 1; comb_chk = 1;
    pkt_len = LW'(4);
    load(0, 8, 4); load(1, 8, 4);
    drive();
    run_phase(2000, 0);
    for (int r = 0; r < 4; r++) begin
      pkt_len = LW'($urandom_range(0, 5));
      for (int c = 0; c < NUM_CH; c++)
        load(c, $urandom_range(0, 6), (pkt_len == '0) ? 1 : int'(pkt_len));
      drive();
      run_phase(2000, 0);
    end
    bp_mode = 0; comb_chk = 0;

    // pkt_len of 0 means single-beat packets
    pkt_len = '0;
    base = exp_pkts;
    load(0, 3, 1); load(1, 2, 1);
    drive();
    run_phase(200, 0);
    chk("len0_pkts", pkt_count, base + 5);

    // pkt_len 4 -> 8 mid-packet only affects the following packet
    pkt_len = LW'(4);
    base = exp_pkts;
    load(0, 1, 4); load(0, 1, 8);
    len_switch_to = 8;
    drive();
    run_phase(200, 0);
    chk("len_switch_pkts", pkt_count, base + 2);

    // reset mid-packet after two beats of four
    pkt_len = LW'(4);
    load(0, 1, 4); load(1, 1, 4);
    drive();
    run_phase(200, 2);
    #2 axi_aresetn = 1'b0;
    #1 chk_rst_outputs("mid_rst");
    for (int c = 0; c < NUM_CH; c++) begin
      src_q[c].delete();
      bubble[c] = 0; acc_last[c] = 0;
    end
    exp_q.delete();
    in_pkt = 0; prev_g = NUM_CH - 1; exp_pkts = 0; stall_prev = 0;
    load(0, 1, 4); load(1, 1, 4);
    drive();
    @(posedge axi_aclk); #1;
    axi_aresetn = 1'b1;
    run_phase(200, 0);
    chk("pkt_cnt_after_rst", pkt_count, 2);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/sddt_rdata_merger.md
# sddt_rdata_merger

Multi-channel read-data aggregator in the `axi_aclk` domain. It sits between the per-channel asynchronous read-data FIFOs (one per DDR4 channel) and the single host-bound read-data AXI-Stream. It arbitrates round-robin at packet granularity and frames each packet with `tlast`, `tkeep` and a channel tag in `tuser`. It also exports status for the debug `state` word.

## Interface
Parameters:
- `NUM_CH`, 2: number of read-data input channels, range 1..8.
- `DATA_WIDTH`, 512: beat width in bits, a multiple of 8.
- `LEN_WIDTH`, 16: width of the runtime packet-length input.

Ports (clock and reset first):
- `axi_aclk`  in  1  sole clock.
- `axi_aresetn`  in  1  reset, asynchronous assert, active-low.
- `S_AXIS_RDATA_tdata`  in  `NUM_CH*DATA_WIDTH`  channel *i* occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `S_AXIS_RDATA_tvalid`  in  `NUM_CH`  per-channel valid.
- `S_AXIS_RDATA_tready`  out  `NUM_CH`  per-channel ready.
- `M_AXIS_RDATA_tdata`  out  `DATA_WIDTH`  merged beat.
- `M_AXIS_RDATA_tvalid`  out  1.
- `M_AXIS_RDATA_tready`  in  1.
- `M_AXIS_RDATA_tlast`  out  1  high on the final beat of a packet.
- `M_AXIS_RDATA_tkeep`  out  `DATA_WIDTH/8`  all ones on every beat.
- `M_AXIS_RDATA_tuser`  out  `CH_ID_WIDTH`  source channel of the beat. `CH_ID_WIDTH` = max(1, clog2(`NUM_CH`)), a localparam.
- `pkt_len`  in  `LEN_WIDTH`  beats per packet. The value 0 is treated as 1.
- `busy`  out  1  high while a packet is in progress.
- `cur_ch`  out  `CH_ID_WIDTH`  currently or most recently granted channel.
- `pkt_count`  out  32  count of completed output packets; wraps.

## Operation
- **FSM states:** IDLE and XFER.
- **Reset state:** FSM in IDLE; all `S_AXIS_RDATA_tready` = 0; `M_AXIS_RDATA_tvalid` = 0; `tlast` = 0; `tdata` = 0; `tuser` = 0; `busy` = 0; `cur_ch` = 0; `pkt_count` = 0; round-robin pointer = `NUM_CH-1`, so channel 0 has first priority.
- **IDLE:**
  - If any `tvalid` is high, grant the first channel with `tvalid` high, searching upward from pointer+1 modulo `NUM_CH`.
  - Latch `len` = max(`pkt_len`, 1), clear the beat counter, set pointer = `cur_ch` = grant, and go to XFER.
  - If no `tvalid` is high, stay in IDLE.
- **XFER:**
  - `S_AXIS_RDATA_tready[grant]` = skid buffer can accept; every other channel's ready is 0.
  - Each accepted beat increments the beat counter.
  - The beat with counter == `len-1` is tagged last. On its acceptance the FSM goes to IDLE.
- **Output beats:** carry `tuser` = grant and `tkeep` = all ones. `tlast` is set on the tagged beat only.
- **Packet count:** `pkt_count` increments when an output beat with `tlast` completes its handshake (`tvalid & tready`).
- **`busy`:** high from the IDLE->XFER transition until the last output beat's handshake completes.
- **Packet locking:** a packet never interleaves channels. Other channels wait even if the granted channel stalls indefinitely.
- **`pkt_len` changes** while in XFER have no effect until the next grant.
- **Single-channel traffic:** that channel is re-granted for every packet.
- **All channels valid:** grants rotate 0,1,…,`NUM_CH-1`,0.
- **Backpressure:** while `M_AXIS_RDATA_tvalid` is high and `tready` is low, `tdata`, `tlast` and `tuser` hold stable. No beat is dropped or duplicated.
- **Reset mid-packet:** the partial packet is discarded and outputs return to reset values immediately. Upstream FIFOs are reset by their own domains.
- **`pkt_count` wrap:** 0xFFFFFFFF wraps to 0.

## Timing
- **Latency:** 1 cycle from input handshake to `M_AXIS_RDATA_tvalid` (registered output).
- **Input ready:** no combinational path from `M_AXIS_RDATA_tready` to any `S_AXIS_RDATA_tready`; a 2-entry skid buffer breaks it.
- **Throughput:** 1 beat/cycle within a packet while `M_AXIS_RDATA_tready` is held high.
- **Inter-packet gap:** exactly 1 cycle on the input side (the IDLE arbitration cycle). The output gap equals the input gap.
- **Arbitration:** grant is registered; the first ready of a packet rises the cycle after IDLE sees valid.

## Structure
- `sddt_pkg` holds the FSM state enum (IDLE, XFER) and the `CH_ID_WIDTH` computation function.
- Sub-module `sddt_axis_skid`: a 2-entry registered skid buffer, parametrised on payload width. Payload is {`tdata`, `tlast`, `tuser`}.
- Arbiter, beat counter and status logic stay in `sddt_rdata_merger`.

## Test plan
- **Reset:** hold `axi_aresetn`=0 with all inputs valid -> every output is 0 and every ready is 0. Release -> first grant is ch0.
- **Single packet:** `NUM_CH`=2, `pkt_len`=4, ch1 sends beats 0xA0..0xA3 with `M_AXIS_RDATA_tready`=1 -> 4 output beats, `tuser`=1, `tlast` on 0xA3 only, `pkt_count`=1, first output 1 cycle after first accept.
- **Round-robin:** ch0 and ch1 continuously valid, `pkt_len`=2 -> `tuser` sequence 0,0,1,1,0,0,1,1; 1-cycle gap between packets.
- **Backpressure:** toggle `M_AXIS_RDATA_tready` randomly over 64 beats -> output equals input order exactly, stable while stalled, no tready combinational dependency.
- **Length corner cases:** `pkt_len`=0 -> every beat carries `tlast`. Change `pkt_len` 4->8 mid-packet -> current packet still 4 beats, next packet 8.
- **Reset mid-packet:** assert reset after beat 2 of 4 -> outputs clear asynchronously. After release, ch0 is granted and a fresh packet starts with `pkt_count`=0.
